// File: rtl/cache_mem_arbiter.sv
// Shared RAM-port arbiter between the icache and dcache control units.
// Holds the dcache grant across a block and gives the icache priority once starved.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      grant_i,
  output logic      grant_d
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BW = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state, next_state;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  word_t         addr_q, store_q;
  logic          d_req, ram_ack, starved, last_beat;

  assign d_req     = dREN | dWEN;
  assign ram_ack   = (ramstate == ACCESS);
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign last_beat = ((beat_cnt + 1'b1) == BW'(BLOCK_WORDS));

  always_comb begin
    next_state = state;
    beat_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (starved && iREN) begin
          next_state = IGRANT;
        end else if (d_req) begin
          next_state = DGRANT;
          beat_nxt   = '0;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT: begin
        if (ram_ack || !iREN) next_state = IDLE;
      end
      DGRANT: begin
        if (ram_ack) beat_nxt = beat_cnt + 1'b1;
        // A dropped request ends the grant even mid-block; the next beat re-arbitrates.
        if (!d_req || (ram_ack && last_beat)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    if (!iREN || (state != IGRANT && next_state == IGRANT)) begin
      starve_nxt = '0;
    end else if (state != IGRANT && !starved) begin
      starve_nxt = starve_cnt + 1'b1;
    end else begin
      starve_nxt = starve_cnt;
    end
  end

  // Address and write data fall back to the last driven values while idle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = addr_q;
    ramstore = store_q;
    case (state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      store_q    <= '0;
    end else begin
      state      <= next_state;
      beat_cnt   <= beat_nxt;
      starve_cnt <= starve_nxt;
      addr_q     <= ramaddr;
      store_q    <= ramstore;
    end
  end

  assign iwait   = ~((state == IGRANT) && ram_ack);
  assign dwait   = ~((state == DGRANT) && ram_ack);
  assign iload   = ramload;
  assign dload   = ramload;
  assign grant_i = (state == IGRANT);
  assign grant_d = (state == DGRANT);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, corner-case sequences,
// and randomized cache/RAM traffic checked against a transaction-level model.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned BLOCK_WORDS  = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, ramREN, ramWEN, grant_i, grant_d;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  word_t ram_mem [16];
  word_t ref_mem [16];
  int    tests  = 0;
  int    failed = 0;

  cache_mem_arbiter #(.BLOCK_WORDS(BLOCK_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_init(input int i);
    if (i == 0) return 32'hDEADBEEF;
    if (i == 2) return 32'hCAFEF00D;
    return 32'h1000_0000 + word_t'(i) * 32'h0101_0101;
  endfunction

  // RAM model: word-indexed by addr[5:2], reloaded while in reset, written on ACCESS.
  assign ramload = ram_mem[ramaddr[5:2]];
  initial forever begin
    @(posedge CLK);
    if (!nRST) begin
      for (int i = 0; i < 16; i++) ram_mem[i] = mem_init(i);
    end else if (ramWEN && ramstate == ACCESS) begin
      ram_mem[ramaddr[5:2]] = ramstore;
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] req;    // {iREN, dREN, dWEN}
    word_t      ia, da, ds;
    ramstate_t  rs;
    logic [5:0] flags;  // {grant_i, grant_d, iwait, dwait, ramREN, ramWEN}
    word_t      addr, store;
    logic [1:0] lc;     // 1: check iload, 2: check dload
    word_t      ld;
  } vec_t;

  vec_t tbl [22];

  // Reference model state (owner 0 none, 1 icache, 2 dcache)
  int    m_owner, m_beats, m_lost;
  word_t m_addr, m_store;
  logic  i_act, d_act, d_wr, d_both, i_ack, d_ack;
  int    d_left;
  int    first_gi, first_gd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every request asserted
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h40; daddr = 32'h80; dstore = 32'h55; ramstate = ACCESS;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset.flags", {grant_i, grant_d, iwait, dwait, ramREN, ramWEN}, 6'b001100);
    chk("reset.ramaddr", ramaddr, 32'h0);
    chk("reset.ramstore", ramstore, 32'h0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("release.arb_cycle.grant_d", grant_d, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("release.dgrant.flags", {grant_i, grant_d, iwait, dwait, ramREN, ramWEN}, 6'b011001);
    chk("release.dgrant.ramaddr", ramaddr, 32'h80);
    chk("release.dgrant.ramstore", ramstore, 32'h55);
    // Reset in the middle of the block, after beat 1
    @(posedge CLK); #1 ramstate = BUSY;
    #2;
    chk("midreset.pre.flags", {grant_d, dwait}, 2'b11);
    nRST = 1'b0; ramstate = ACCESS;
    #1;
    chk("midreset.flags", {grant_i, grant_d, iwait, dwait, ramREN, ramWEN}, 6'b001100);
    chk("midreset.ramaddr", ramaddr, 32'h0);
    chk("midreset.ramstore", ramstore, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk($sformatf("midreset.hold%0d.dwait", k), {grant_d, dwait}, 2'b01);
    end

    // Directed vectors, one per cycle, starting straight out of reset
    tbl[0]  = '{3'b100, 32'h100, 32'h0,   32'h0,        ACCESS, 6'b001100, 32'h0,   32'h0,        2'd0, 32'h0};
    tbl[1]  = '{3'b100, 32'h100, 32'h0,   32'h0,        ACCESS, 6'b100110, 32'h100, 32'h0,        2'd1, 32'hDEADBEEF};
    tbl[2]  = '{3'b000, 32'h100, 32'h0,   32'h0,        FREE,   6'b001100, 32'h100, 32'h0,        2'd0, 32'h0};
    tbl[3]  = '{3'b001, 32'h0,   32'h200, 32'h11111111, BUSY,   6'b001100, 32'h100, 32'h0,        2'd0, 32'h0};
    tbl[4]  = '{3'b001, 32'h0,   32'h200, 32'h11111111, BUSY,   6'b011101, 32'h200, 32'h11111111, 2'd0, 32'h0};
    tbl[5]  = '{3'b001, 32'h0,   32'h200, 32'h11111111, ACCESS, 6'b011001, 32'h200, 32'h11111111, 2'd0, 32'h0};
    tbl[6]  = '{3'b001, 32'h0,   32'h204, 32'h22222222, BUSY,   6'b011101, 32'h204, 32'h22222222, 2'd0, 32'h0};
    tbl[7]  = '{3'b001, 32'h0,   32'h204, 32'h22222222, ACCESS, 6'b011001, 32'h204, 32'h22222222, 2'd0, 32'h0};
    tbl[8]  = '{3'b000, 32'h0,   32'h0,   32'h0,        FREE,   6'b001100, 32'h204, 32'h22222222, 2'd0, 32'h0};
    tbl[9]  = '{3'b100, 32'h148, 32'h0,   32'h0,        ERROR,  6'b001100, 32'h204, 32'h22222222, 2'd0, 32'h0};
    tbl[10] = '{3'b100, 32'h148, 32'h0,   32'h0,        ERROR,  6'b101110, 32'h148, 32'h22222222, 2'd0, 32'h0};
    tbl[11] = '{3'b100, 32'h148, 32'h0,   32'h0,        ERROR,  6'b101110, 32'h148, 32'h22222222, 2'd0, 32'h0};
    tbl[12] = '{3'b100, 32'h148, 32'h0,   32'h0,        ERROR,  6'b101110, 32'h148, 32'h22222222, 2'd0, 32'h0};
    tbl[13] = '{3'b100, 32'h148, 32'h0,   32'h0,        ACCESS, 6'b100110, 32'h148, 32'h22222222, 2'd1, 32'hCAFEF00D};
    tbl[14] = '{3'b000, 32'h148, 32'h0,   32'h0,        FREE,   6'b001100, 32'h148, 32'h22222222, 2'd0, 32'h0};
    tbl[15] = '{3'b100, 32'h200, 32'h0,   32'h0,        ACCESS, 6'b001100, 32'h148, 32'h22222222, 2'd0, 32'h0};
    tbl[16] = '{3'b100, 32'h200, 32'h0,   32'h0,        ACCESS, 6'b100110, 32'h200, 32'h22222222, 2'd1, 32'h11111111};
    tbl[17] = '{3'b000, 32'h200, 32'h0,   32'h0,        FREE,   6'b001100, 32'h200, 32'h22222222, 2'd0, 32'h0};
    tbl[18] = '{3'b110, 32'h100, 32'h208, 32'h33333333, ACCESS, 6'b001100, 32'h200, 32'h22222222, 2'd0, 32'h0};
    tbl[19] = '{3'b110, 32'h100, 32'h208, 32'h33333333, ACCESS, 6'b011010, 32'h208, 32'h33333333, 2'd2, 32'hCAFEF00D};
    tbl[20] = '{3'b000, 32'h100, 32'h208, 32'h33333333, FREE,   6'b011100, 32'h208, 32'h33333333, 2'd0, 32'h0};
    tbl[21] = '{3'b000, 32'h0,   32'h0,   32'h0,        FREE,   6'b001100, 32'h208, 32'h33333333, 2'd0, 32'h0};

    {iREN, dREN, dWEN} = 3'b000; iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE;
    @(posedge CLK); #1 nRST = 1'b1;
    foreach (tbl[k]) begin
      {iREN, dREN, dWEN} = tbl[k].req;
      iaddr = tbl[k].ia; daddr = tbl[k].da; dstore = tbl[k].ds; ramstate = tbl[k].rs;
      @(negedge CLK);
      chk($sformatf("v%0d.flags{gi,gd,iw,dw,ren,wen}", k),
          {grant_i, grant_d, iwait, dwait, ramREN, ramWEN}, tbl[k].flags);
      chk($sformatf("v%0d.ramaddr", k), ramaddr, tbl[k].addr);
      chk($sformatf("v%0d.ramstore", k), ramstore, tbl[k].store);
      if (tbl[k].lc == 2'd1) chk($sformatf("v%0d.iload", k), iload, tbl[k].ld);
      if (tbl[k].lc == 2'd2) chk($sformatf("v%0d.dload", k), dload, tbl[k].ld);
      @(posedge CLK); #1;
    end

    // Contention: dcache keeps re-requesting, 1-cycle RAM; icache must break through
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; iaddr = 32'h100; daddr = 32'h208; ramstate = ACCESS;
    first_gi = -1; first_gd = -1;
    for (int c = 0; c < 20 && first_gi < 0; c++) begin
      @(negedge CLK);
      if (grant_d && first_gd < 0) first_gd = c;
      if (grant_i) first_gi = c;
      @(posedge CLK); #1;
    end
    chk("contention.first_dgrant_cycle", word_t'(first_gd), 32'd1);
    chk("contention.igrant_cycle", word_t'(first_gi), 32'd7);

    // Randomized traffic against the reference model
    nRST = 1'b0; {iREN, dREN, dWEN} = 3'b000; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
    m_owner = 0; m_beats = 0; m_lost = 0; m_addr = '0; m_store = '0;
    i_act = 1'b0; d_act = 1'b0; d_wr = 1'b0; d_both = 1'b0; i_ack = 1'b0; d_ack = 1'b0; d_left = 0;
    for (int c = 0; c < 1500; c++) begin
      logic  acc, e_gi, e_gd, e_iw, e_dw, e_ren, e_wen, dq;
      word_t e_addr, e_store;
      int    n_owner, r;
      // icache agent: holds a request until acked, occasionally abandons it
      if (i_act) begin
        if (i_ack || $urandom_range(0, 99) < 3) i_act = 1'b0;
      end else if (!iREN && $urandom_range(0, 99) < 30) begin
        i_act = 1'b1;
        iaddr = word_t'($urandom_range(0, 63)) << 2;
      end
      iREN = i_act;
      // dcache agent: blocks of 1..BLOCK_WORDS beats, read or write
      if (d_act) begin
        if (d_ack) begin
          d_left--;
          if (d_left == 0) d_act = 1'b0;
          else begin daddr = daddr + 32'd4; dstore = $urandom; end
        end else if ($urandom_range(0, 99) < 3) begin
          d_act = 1'b0;
        end
      end else if (!(dREN || dWEN) && $urandom_range(0, 99) < 30) begin
        d_act  = 1'b1;
        d_left = int'($urandom_range(1, BLOCK_WORDS));
        d_wr   = 1'($urandom_range(0, 1));
        d_both = 1'($urandom_range(0, 1));
        daddr  = word_t'($urandom_range(0, 63)) << 2;
        dstore = $urandom;
      end
      dWEN = d_act && d_wr;
      dREN = d_act && (!d_wr || d_both);
      r = int'($urandom_range(0, 9));
      ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;

      @(negedge CLK);
      acc     = (ramstate == ACCESS);
      e_gi    = (m_owner == 1);
      e_gd    = (m_owner == 2);
      e_iw    = !(e_gi && acc);
      e_dw    = !(e_gd && acc);
      e_ren   = e_gi ? iREN : (e_gd ? (dREN && !dWEN) : 1'b0);
      e_wen   = e_gd && dWEN;
      e_addr  = e_gi ? iaddr : (e_gd ? daddr : m_addr);
      e_store = e_gd ? dstore : m_store;
      chk("rnd.flags{gi,gd,iw,dw,ren,wen}", {grant_i, grant_d, iwait, dwait, ramREN, ramWEN},
          {e_gi, e_gd, e_iw, e_dw, e_ren, e_wen});
      chk("rnd.ramaddr", ramaddr, e_addr);
      chk("rnd.ramstore", ramstore, e_store);
      if (!e_iw) chk("rnd.iload", iload, ref_mem[iaddr[5:2]]);
      if (!e_dw && dREN && !dWEN) chk("rnd.dload", dload, ref_mem[daddr[5:2]]);
      if (!e_dw && dWEN) ref_mem[daddr[5:2]] = dstore;
      i_ack = !e_iw && iREN;
      dq    = dREN || dWEN;
      d_ack = !e_dw && dq;

      // Ownership rules: starved icache first, then dcache, then icache
      n_owner = m_owner;
      case (m_owner)
        0: begin
          if (iREN && m_lost >= int'(STARVE_LIMIT)) n_owner = 1;
          else if (dq) begin n_owner = 2; m_beats = 0; end
          else if (iREN) n_owner = 1;
        end
        1: if (acc || !iREN) n_owner = 0;
        default: begin
          if (acc) m_beats++;
          if (!dq || (acc && m_beats == int'(BLOCK_WORDS))) n_owner = 0;
        end
      endcase
      if (!iREN || (n_owner == 1 && m_owner != 1)) m_lost = 0;
      else if (m_owner != 1 && m_lost < int'(STARVE_LIMIT)) m_lost++;
      m_owner = n_owner;
      m_addr  = e_addr;
      m_store = e_store;
      @(posedge CLK); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
